// File: rtl/channel_readout_scheduler.sv
// Round-robin readout of eight FWFT channel FIFOs into header/data/trailer frames,
// with idle heartbeat frames and a registered valid/ready output stage.
module channel_readout_scheduler #(
    parameter int unsigned NCH = 8,
    parameter int unsigned DW  = 120
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_enable,
    input  logic [11:0]       idle_th,
    input  logic [4:0]        max_words,
    input  logic [47:0]       D_MAC_add,
    input  logic [47:0]       S_MAC_add,
    input  logic [7:0]        channel_linked,
    input  logic [NCH-1:0]    ch_empty,
    input  logic [NCH*DW-1:0] ch_data,
    output logic [NCH-1:0]    ch_rd,
    output logic [DW-1:0]     out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [7:0]        frame_cnt,
    output logic              busy
);

    localparam int unsigned PW   = $clog2(NCH);
    localparam int unsigned IW   = 12;
    localparam int unsigned WW   = 5;
    localparam int unsigned FW   = 8;
    localparam int unsigned PAYW = DW - 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DATA = 2'd1;
    localparam logic [1:0] LAST = 2'd2;

    localparam logic [WW-1:0] MAX_LIMIT = WW'(16);

    logic [1:0]      state, state_d;
    logic [PW-1:0]   rr_ptr, rr_ptr_d;
    logic [WW-1:0]   word_cnt, word_cnt_d;
    logic [IW-1:0]   idle_cnt, idle_cnt_d;
    logic [DW-1:0]   out_data_d;
    logic            out_valid_d, out_last_d;
    logic [FW-1:0]   frame_cnt_d;

    logic [PAYW-1:0] ch_pay [NCH];
    logic            unused_tag;
    logic [PW-1:0]   grant, idx;
    logic            grant_vld;
    logic [WW-1:0]   limit;
    logic            load, trigger;

    // Channel heads minus their top nibble, which the data word replaces with the tag.
    always_comb begin
        unused_tag = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            ch_pay[i]  = ch_data[i*DW +: PAYW];
            unused_tag = unused_tag ^ (^ch_data[i*DW+PAYW +: 4]);
        end
    end

    // First non-empty channel at or after rr_ptr, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        idx       = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            idx = PW'(rr_ptr + PW'(k));
            if (!grant_vld && !ch_empty[idx]) begin
                grant_vld = 1'b1;
                grant     = idx;
            end
        end
    end

    assign limit   = (max_words == '0) ? MAX_LIMIT : max_words;
    assign load    = ~out_valid | out_ready;
    assign trigger = cfg_enable & ((|(~ch_empty)) | ((idle_th != '0) & (idle_cnt == idle_th)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            word_cnt  <= '0;
            idle_cnt  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            frame_cnt <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_ptr_d;
            word_cnt  <= word_cnt_d;
            idle_cnt  <= idle_cnt_d;
            out_data  <= out_data_d;
            out_valid <= out_valid_d;
            out_last  <= out_last_d;
            frame_cnt <= frame_cnt_d;
            busy      <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d     = state;
        rr_ptr_d    = rr_ptr;
        word_cnt_d  = word_cnt;
        idle_cnt_d  = idle_cnt;
        out_data_d  = out_data;
        out_valid_d = out_valid;
        out_last_d  = out_last;
        frame_cnt_d = frame_cnt;
        ch_rd       = '0;
        case (state)
            IDLE: begin
                if (cfg_enable && (&ch_empty) && (idle_cnt != '1)) begin
                    idle_cnt_d = idle_cnt + IW'(1);
                end
                if (trigger && load) begin
                    out_data_d  = {D_MAC_add, S_MAC_add, frame_cnt, 8'h00, 8'hFF};
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b0;
                    frame_cnt_d = frame_cnt + FW'(1);
                    word_cnt_d  = '0;
                    idle_cnt_d  = '0;
                    state_d     = DATA;
                end
            end
            DATA: begin
                if (load) begin
                    if (grant_vld && (word_cnt < limit)) begin
                        out_data_d = {1'b1, grant, ch_pay[grant]};
                        ch_rd      = {{(NCH-1){1'b0}}, 1'b1} << grant;
                        rr_ptr_d   = PW'(grant + PW'(1));
                        word_cnt_d = word_cnt + WW'(1);
                    end else begin
                        out_data_d = {{(DW-16){1'b0}}, 4'hF, 4'h0, channel_linked};
                        out_last_d = 1'b1;
                        state_d    = LAST;
                    end
                    out_valid_d = 1'b1;
                end
            end
            LAST: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_channel_readout_scheduler.sv
// Directed bench for channel_readout_scheduler: counter-based FWFT channel model,
// accepted-word monitor, and per-scenario tasks with hand-computed frames.
module tb_channel_readout_scheduler;

    localparam int unsigned NCH = 8;
    localparam int unsigned DW  = 120;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_enable;
    logic [11:0]       idle_th;
    logic [4:0]        max_words;
    logic [47:0]       dmac;
    logic [47:0]       smac;
    logic [7:0]        linked;
    logic [NCH-1:0]    ch_empty;
    logic [NCH*DW-1:0] ch_data;
    logic [NCH-1:0]    ch_rd;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [7:0]        frame_cnt;
    logic              busy;

    int n_chk = 0;
    int n_fail = 0;

    int wr_cnt [NCH];
    int rd_cnt [NCH];
    int cyc = 0;
    logic [DW:0]    acc_q [$];
    int             acc_t [$];
    logic [NCH-1:0] rd_q  [$];

    always #5 clk = ~clk;

    channel_readout_scheduler #(.NCH(NCH), .DW(DW)) dut (
        .clk(clk), .reset(reset), .cfg_enable(cfg_enable), .idle_th(idle_th),
        .max_words(max_words), .D_MAC_add(dmac), .S_MAC_add(smac),
        .channel_linked(linked), .ch_empty(ch_empty), .ch_data(ch_data),
        .ch_rd(ch_rd), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .frame_cnt(frame_cnt), .busy(busy)
    );

    function automatic logic [DW-1:0] head(input int ch, input int k);
        return {4'hA, 84'h0, 8'(ch), 8'h5C, 16'(k)};
    endfunction

    function automatic logic [DW:0] w_hdr(input logic [7:0] fc);
        return {1'b0, dmac, smac, fc, 8'h00, 8'hFF};
    endfunction

    function automatic logic [DW:0] w_dat(input int ch, input int k);
        return {1'b0, 1'b1, 3'(ch), 84'h0, 8'(ch), 8'h5C, 16'(k)};
    endfunction

    function automatic logic [DW:0] w_trl();
        return {1'b1, 104'h0, 4'hF, 4'h0, linked};
    endfunction

    // FWFT channel model: the head is word rd_cnt of that channel.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ch_empty[i]           = (wr_cnt[i] == rd_cnt[i]);
            ch_data[i*DW +: DW]   = head(i, rd_cnt[i]);
        end
    end

    // Records accepted words and pops at each rising edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            if (out_valid && out_ready) begin
                acc_q.push_back({out_last, out_data});
                acc_t.push_back(cyc);
            end
            if (ch_rd != '0) begin
                rd_q.push_back(ch_rd);
                for (int i = 0; i < NCH; i++) if (ch_rd[i]) rd_cnt[i] <= rd_cnt[i] + 1;
            end
        end
    end

    task automatic do_reset();
        reset = 1'b0;
        cfg_enable = 1'b0;
        out_ready = 1'b1;
        idle_th = 12'd0;
        max_words = 5'd16;
        for (int i = 0; i < NCH; i++) wr_cnt[i] = rd_cnt[i];
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        acc_q.delete();
        acc_t.delete();
        rd_q.delete();
    endtask

    task automatic wait_words(input int n, input int budget);
        for (int i = 0; i < budget && acc_q.size() < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        n_chk++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset out_last: got %b want 0", out_last); end
        n_chk++; if (out_data !== '0) begin n_fail++; $display("FAIL reset out_data: got %h want 0", out_data); end
        n_chk++; if (ch_rd !== '0) begin n_fail++; $display("FAIL reset ch_rd: got %h want 0", ch_rd); end
        n_chk++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL reset frame_cnt: got %0d want 0", frame_cnt); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
    endtask

    task automatic test_single_channel();
        logic [DW:0] exp_q [$];
        do_reset();
        wr_cnt[3] += 2;
        cfg_enable = 1'b1;
        wait_words(4, 40);
        exp_q = '{w_hdr(8'd0), w_dat(3, 0), w_dat(3, 1), w_trl()};
        n_chk++; if (acc_q.size() != 4) begin n_fail++; $display("FAIL single size: got %0d want 4", acc_q.size()); end
        if (acc_q.size() == 4) begin
            foreach (exp_q[i]) begin
                n_chk++;
                if (acc_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL single word %0d: got %h want %h", i, acc_q[i], exp_q[i]); end
            end
            n_chk++; if (acc_t[3] - acc_t[0] != 3) begin n_fail++; $display("FAIL single back_to_back: got %0d want 3", acc_t[3] - acc_t[0]); end
        end
        n_chk++; if (rd_q.size() != 2) begin n_fail++; $display("FAIL single rd_count: got %0d want 2", rd_q.size()); end
        foreach (rd_q[i]) begin
            n_chk++; if (rd_q[i] !== 8'h08) begin n_fail++; $display("FAIL single rd_value: got %h want 08", rd_q[i]); end
        end
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (frame_cnt !== 8'd1) begin n_fail++; $display("FAIL single frame_cnt: got %0d want 1", frame_cnt); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single busy_after: got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        logic [DW:0] exp_q [$];
        do_reset();
        wr_cnt[0] += 2; wr_cnt[5] += 2; wr_cnt[7] += 2;
        cfg_enable = 1'b1;
        wait_words(8, 40);
        exp_q = '{w_hdr(8'd0), w_dat(0, 0), w_dat(5, 0), w_dat(7, 0),
                  w_dat(0, 1), w_dat(5, 1), w_dat(7, 1), w_trl()};
        n_chk++; if (acc_q.size() != 8) begin n_fail++; $display("FAIL rr size: got %0d want 8", acc_q.size()); end
        if (acc_q.size() == 8) foreach (exp_q[i]) begin
            n_chk++;
            if (acc_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rr word %0d: got %h want %h", i, acc_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_max_words();
        logic [DW:0] exp_q [$];
        do_reset();
        max_words = 5'd0;
        wr_cnt[1] += 20;
        cfg_enable = 1'b1;
        wait_words(24, 100);
        exp_q.push_back(w_hdr(8'd0));
        for (int k = 0; k < 16; k++) exp_q.push_back(w_dat(1, k));
        exp_q.push_back(w_trl());
        exp_q.push_back(w_hdr(8'd1));
        for (int k = 16; k < 20; k++) exp_q.push_back(w_dat(1, k));
        exp_q.push_back(w_trl());
        n_chk++; if (acc_q.size() != 24) begin n_fail++; $display("FAIL maxw size: got %0d want 24", acc_q.size()); end
        if (acc_q.size() == 24) foreach (exp_q[i]) begin
            n_chk++;
            if (acc_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL maxw word %0d: got %h want %h", i, acc_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_heartbeat();
        logic [DW:0] exp_q [$];
        do_reset();
        idle_th = 12'd10;
        cfg_enable = 1'b1;
        wait_words(6, 80);
        exp_q = '{w_hdr(8'd0), w_trl(), w_hdr(8'd1), w_trl(), w_hdr(8'd2), w_trl()};
        n_chk++; if (acc_q.size() != 6) begin n_fail++; $display("FAIL hb size: got %0d want 6", acc_q.size()); end
        if (acc_q.size() == 6) begin
            foreach (exp_q[i]) begin
                n_chk++;
                if (acc_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL hb word %0d: got %h want %h", i, acc_q[i], exp_q[i]); end
            end
            n_chk++; if (acc_t[1] - acc_t[0] != 1) begin n_fail++; $display("FAIL hb hdr_to_trl: got %0d want 1", acc_t[1] - acc_t[0]); end
            n_chk++; if (acc_t[2] - acc_t[1] != 12) begin n_fail++; $display("FAIL hb period1: got %0d want 12", acc_t[2] - acc_t[1]); end
            n_chk++; if (acc_t[4] - acc_t[3] != 12) begin n_fail++; $display("FAIL hb period2: got %0d want 12", acc_t[4] - acc_t[3]); end
        end
        do_reset();
        cfg_enable = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        n_chk++; if (acc_q.size() != 0) begin n_fail++; $display("FAIL hb disabled: got %0d words want 0", acc_q.size()); end
        n_chk++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL hb disabled frame_cnt: got %0d want 0", frame_cnt); end
    endtask

    task automatic test_stall();
        logic [DW:0]   exp_q [$];
        logic [3:0]    pat;
        logic [DW-1:0] prev_d;
        logic          prev_stall;
        logic          done;
        int            stalls;
        pat = 4'b1001;
        stalls = 0;
        done = 1'b0;
        do_reset();
        wr_cnt[6] += 3;
        cfg_enable = 1'b1;
        for (int c = 0; c < 80 && !done; c++) begin
            out_ready  = pat[c % 4];
            prev_d     = out_data;
            prev_stall = out_valid & ~out_ready;
            @(posedge clk);
            #1;
            if (prev_stall) begin
                stalls++;
                n_chk++;
                if (out_data !== prev_d || out_valid !== 1'b1) begin
                    n_fail++; $display("FAIL stall hold: got %h valid %b want %h valid 1", out_data, out_valid, prev_d);
                end
            end
            if (busy) cfg_enable = 1'b0;
            if (acc_q.size() > 0 && acc_q[acc_q.size()-1][DW]) done = 1'b1;
        end
        out_ready = 1'b1;
        n_chk++; if (stalls < 2) begin n_fail++; $display("FAIL stall occurrences: got %0d want >=2", stalls); end
        exp_q = '{w_hdr(8'd0), w_dat(6, 0), w_dat(6, 1), w_dat(6, 2), w_trl()};
        n_chk++; if (acc_q.size() != 5) begin n_fail++; $display("FAIL stall size: got %0d want 5", acc_q.size()); end
        if (acc_q.size() == 5) foreach (exp_q[i]) begin
            n_chk++;
            if (acc_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall word %0d: got %h want %h", i, acc_q[i], exp_q[i]); end
        end
        n_chk++; if (rd_q.size() != 3) begin n_fail++; $display("FAIL stall rd_count: got %0d want 3", rd_q.size()); end
        foreach (rd_q[i]) begin
            n_chk++; if (rd_q[i] !== 8'h40) begin n_fail++; $display("FAIL stall rd_value: got %h want 40", rd_q[i]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        wr_cnt[3] += 4;
        cfg_enable = 1'b1;
        wait_words(2, 20);
        reset = 1'b0;
        #1;
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst out_valid: got %b want 0", out_valid); end
        n_chk++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL midrst out_last: got %b want 0", out_last); end
        n_chk++; if (out_data !== '0) begin n_fail++; $display("FAIL midrst out_data: got %h want 0", out_data); end
        n_chk++; if (ch_rd !== '0) begin n_fail++; $display("FAIL midrst ch_rd: got %h want 0", ch_rd); end
        n_chk++; if (frame_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst frame_cnt: got %0d want 0", frame_cnt); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst busy: got %b want 0", busy); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        acc_q.delete();
        acc_t.delete();
        wait_words(1, 20);
        n_chk++; if (acc_q.size() < 1) begin n_fail++; $display("FAIL midrst restart: got %0d words want 1", acc_q.size()); end
        if (acc_q.size() >= 1) begin
            n_chk++;
            if (acc_q[0] !== w_hdr(8'd0)) begin n_fail++; $display("FAIL midrst first_word: got %h want %h", acc_q[0], w_hdr(8'd0)); end
        end
    endtask

    initial begin
        reset = 1'b0;
        cfg_enable = 1'b0;
        idle_th = 12'd0;
        max_words = 5'd16;
        out_ready = 1'b1;
        dmac = 48'h0011_2233_4455;
        smac = 48'hA0B1_C2D3_E4F5;
        linked = 8'hA5;
        test_reset();
        test_single_channel();
        test_round_robin();
        test_max_words();
        test_heartbeat();
        test_stall();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
